// File: rtl/ysyx_210544_trap_csr_arbiter_pkg.sv
// Shared constants and types for the trap/CSR port arbiter.
// Holds the FSM encodings, the trap opcodes and the CSR command bundle.
package ysyx_210544_trap_csr_arbiter_pkg;

  localparam logic [1:0] ARB_S_IDLE = 2'd0;
  localparam logic [1:0] ARB_S_INS  = 2'd1;
  localparam logic [1:0] ARB_S_EXC  = 2'd2;

  localparam logic [7:0] INST_ECALL = 8'h50;
  localparam logic [7:0] INST_MRET  = 8'h51;

  typedef struct packed {
    logic [11:0] addr;
    logic        ren;
    logic        wen;
    logic [63:0] wdata;
  } csr_cmd_t;

endpackage

// File: rtl/ysyx_210544_csr_port_mux.sv
// 2:1 selector for the CSR-file command port (exceptionU vs CSR-instruction unit).
module ysyx_210544_csr_port_mux
  import ysyx_210544_trap_csr_arbiter_pkg::*;
(
  input  logic     sel_exc,
  input  csr_cmd_t exc_cmd,
  input  csr_cmd_t ins_cmd,
  output csr_cmd_t csr_cmd
);

  always_comb begin
    csr_cmd = sel_exc ? exc_cmd : ins_cmd;
  end

endmodule

// File: rtl/ysyx_210544_trap_csr_arbiter.sv
// Shares the CSR-file port between the trap sequencer and the CSR-instruction unit;
// captures one-cycle trap pulses and launches exceptionU once the port is free.
module ysyx_210544_trap_csr_arbiter
  import ysyx_210544_trap_csr_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_trap_valid,
  input  logic [7:0]  i_trap_opcode,
  input  logic [63:0] i_trap_pc,
  output logic        o_trap_busy,
  output logic        o_exc_ena,
  output logic [7:0]  o_exc_opcode,
  output logic [63:0] o_exc_pc,
  input  logic        i_exc_req,
  output logic        o_exc_ack,
  input  logic [11:0] i_exc_csr_addr,
  input  logic        i_exc_csr_ren,
  input  logic        i_exc_csr_wen,
  input  logic [63:0] i_exc_csr_wdata,
  input  logic [11:0] i_ins_csr_addr,
  input  logic        i_ins_csr_ren,
  input  logic        i_ins_csr_wen,
  input  logic [63:0] i_ins_csr_wdata,
  input  logic        i_ins_lock,
  output logic        o_ins_stall,
  output logic [11:0] o_csr_addr,
  output logic        o_csr_ren,
  output logic        o_csr_wen,
  output logic [63:0] o_csr_wdata,
  input  logic [63:0] i_csr_rdata,
  output logic [63:0] o_csr_rdata,
  output logic [1:0]  o_err
);

  logic [1:0]       state_q,   state_d;
  logic             pending_q, pending_d;
  logic [7:0]       opcode_q,  opcode_d;
  logic [63:0]      pc_q,      pc_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       err_q,     err_d;

  logic     in_exc;
  csr_cmd_t exc_cmd, ins_cmd, csr_cmd;

  assign in_exc = (state_q == ARB_S_EXC);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    opcode_d  = opcode_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    err_d     = err_q;

    // A pulse is only accepted when nothing is queued and exceptionU is not running.
    if (i_trap_valid) begin
      if (!pending_q && !in_exc) begin
        pending_d = 1'b1;
        opcode_d  = i_trap_opcode;
        pc_d      = i_trap_pc;
      end else begin
        err_d[1] = 1'b1;
      end
    end

    case (state_q)
      ARB_S_IDLE: begin
        if (i_ins_lock) begin
          state_d = ARB_S_INS;
        end else if (pending_q) begin
          state_d   = ARB_S_EXC;
          pending_d = 1'b0;
          cnt_d     = '0;
        end
      end
      ARB_S_INS: begin
        if (!i_ins_lock) state_d = ARB_S_IDLE;
      end
      ARB_S_EXC: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_exc_req) begin
          state_d = ARB_S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = ARB_S_IDLE;
          err_d[0] = 1'b1;
        end
      end
      default: state_d = ARB_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_S_IDLE;
      pending_q <= 1'b0;
      opcode_q  <= '0;
      pc_q      <= '0;
      cnt_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      opcode_q  <= opcode_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign exc_cmd = '{addr: i_exc_csr_addr, ren: i_exc_csr_ren,
                     wen: i_exc_csr_wen, wdata: i_exc_csr_wdata};
  assign ins_cmd = '{addr: i_ins_csr_addr, ren: i_ins_csr_ren,
                     wen: i_ins_csr_wen, wdata: i_ins_csr_wdata};

  ysyx_210544_csr_port_mux u_port_mux (
    .sel_exc (in_exc),
    .exc_cmd (exc_cmd),
    .ins_cmd (ins_cmd),
    .csr_cmd (csr_cmd)
  );

  assign o_csr_addr  = csr_cmd.addr;
  assign o_csr_ren   = csr_cmd.ren;
  assign o_csr_wen   = csr_cmd.wen;
  assign o_csr_wdata = csr_cmd.wdata;
  assign o_csr_rdata = i_csr_rdata;

  // cnt_q is cleared on entry, so zero marks the first S_EXC cycle.
  assign o_exc_ena    = in_exc && (cnt_q == '0);
  assign o_exc_ack    = in_exc && i_exc_req;
  assign o_ins_stall  = (i_ins_csr_ren | i_ins_csr_wen | i_ins_lock) & in_exc;
  assign o_trap_busy  = pending_q | in_exc;
  assign o_exc_opcode = opcode_q;
  assign o_exc_pc     = pc_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_ysyx_210544_trap_csr_arbiter.sv
// Directed bench for the trap/CSR port arbiter: a cycle table plus timeout and reset sequences.
module tb_ysyx_210544_trap_csr_arbiter;
  import ysyx_210544_trap_csr_arbiter_pkg::*;

  localparam logic [11:0] INS_ADDR = 12'h300;
  localparam logic [11:0] EXC_ADDR = 12'h341;
  localparam logic [63:0] INS_WD   = 64'h1111_0000_1111_0000;
  localparam logic [63:0] EXC_WD   = 64'h2222_0000_2222_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tv;
  logic [7:0]  top;
  logic [63:0] tpc;
  logic        busy, ena, ack, stall;
  logic [7:0]  xop;
  logic [63:0] xpc;
  logic        ereq, eren, ewen, iren, iwen, lock;
  logic [11:0] eaddr, iaddr, caddr;
  logic [63:0] ewd, iwd, cwd, rdata_in, rdata_out;
  logic        cren, cwen;
  logic [1:0]  err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_210544_trap_csr_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_trap_valid(tv), .i_trap_opcode(top), .i_trap_pc(tpc),
    .o_trap_busy(busy), .o_exc_ena(ena), .o_exc_opcode(xop), .o_exc_pc(xpc),
    .i_exc_req(ereq), .o_exc_ack(ack),
    .i_exc_csr_addr(eaddr), .i_exc_csr_ren(eren), .i_exc_csr_wen(ewen), .i_exc_csr_wdata(ewd),
    .i_ins_csr_addr(iaddr), .i_ins_csr_ren(iren), .i_ins_csr_wen(iwen), .i_ins_csr_wdata(iwd),
    .i_ins_lock(lock), .o_ins_stall(stall),
    .o_csr_addr(caddr), .o_csr_ren(cren), .o_csr_wen(cwen), .o_csr_wdata(cwd),
    .i_csr_rdata(rdata_in), .o_csr_rdata(rdata_out), .o_err(err)
  );

  typedef struct {
    logic        tv;
    logic [7:0]  op;
    logic [63:0] pc;
    logic        lock, iren, iwen, ereq, eren, ewen;
    logic        busy, ena, ack, stall, sel_exc, ren, wen;
    logic [1:0]  err;
    logic [7:0]  xop;
    logic [63:0] xpc;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic zero_inputs();
    tv = 0; top = '0; tpc = '0; lock = 0; iren = 0; iwen = 0;
    ereq = 0; eren = 0; ewen = 0;
    iaddr = '0; iwd = '0; eaddr = '0; ewd = '0;
  endtask

  function automatic vec_t mk(input logic t, input logic [7:0] op, input logic [63:0] pc,
                              input logic lk, input logic ir, input logic iw,
                              input logic rq, input logic er, input logic ew,
                              input logic b, input logic en, input logic ak, input logic st,
                              input logic se, input logic rn, input logic wn,
                              input logic [1:0] e, input logic [7:0] xo, input logic [63:0] xp);
    vec_t v;
    v.tv = t; v.op = op; v.pc = pc; v.lock = lk; v.iren = ir; v.iwen = iw;
    v.ereq = rq; v.eren = er; v.ewen = ew;
    v.busy = b; v.ena = en; v.ack = ak; v.stall = st; v.sel_exc = se; v.ren = rn; v.wen = wn;
    v.err = e; v.xop = xo; v.xpc = xp;
    return v;
  endfunction

  vec_t vecs[14];

  initial begin
    int n;
    logic found, ack_seen;

    //            tv op          pc            lk ir iw rq er ew  bsy ena ack stl sel ren wen err    xop         xpc
    vecs[0]  = mk(0, 8'h00,      64'h0,        0, 1, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  0,  2'b00, 8'h00,      64'h0);
    vecs[1]  = mk(1, INST_ECALL, 64'h8000_0100,0, 1, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  0,  2'b00, 8'h00,      64'h0);
    vecs[2]  = mk(0, 8'h00,      64'h0,        0, 0, 0, 0, 1, 0,  1,  0,  0,  0,  0,  0,  0,  2'b00, INST_ECALL, 64'h8000_0100);
    vecs[3]  = mk(0, 8'h00,      64'h0,        0, 0, 1, 0, 1, 0,  1,  1,  0,  1,  1,  1,  0,  2'b00, INST_ECALL, 64'h8000_0100);
    vecs[4]  = mk(1, INST_MRET,  64'hdead,     0, 0, 1, 0, 0, 1,  1,  0,  0,  1,  1,  0,  1,  2'b00, INST_ECALL, 64'h8000_0100);
    vecs[5]  = mk(0, 8'h00,      64'h0,        0, 0, 1, 1, 0, 0,  1,  0,  1,  1,  1,  0,  0,  2'b10, INST_ECALL, 64'h8000_0100);
    vecs[6]  = mk(0, 8'h00,      64'h0,        0, 0, 1, 0, 0, 0,  0,  0,  0,  0,  0,  0,  1,  2'b10, INST_ECALL, 64'h8000_0100);
    vecs[7]  = mk(0, 8'h00,      64'h0,        1, 1, 0, 0, 0, 0,  0,  0,  0,  0,  0,  1,  0,  2'b10, INST_ECALL, 64'h8000_0100);
    vecs[8]  = mk(1, INST_MRET,  64'h8000_0200,1, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  2'b10, INST_ECALL, 64'h8000_0100);
    vecs[9]  = mk(0, 8'h00,      64'h0,        1, 0, 1, 0, 0, 0,  1,  0,  0,  0,  0,  0,  1,  2'b10, INST_MRET,  64'h8000_0200);
    vecs[10] = mk(0, 8'h00,      64'h0,        0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  0,  0,  2'b10, INST_MRET,  64'h8000_0200);
    vecs[11] = mk(0, 8'h00,      64'h0,        0, 0, 0, 0, 0, 0,  1,  0,  0,  0,  0,  0,  0,  2'b10, INST_MRET,  64'h8000_0200);
    vecs[12] = mk(0, 8'h00,      64'h0,        0, 0, 0, 1, 0, 0,  1,  1,  1,  0,  1,  0,  0,  2'b10, INST_MRET,  64'h8000_0200);
    vecs[13] = mk(0, 8'h00,      64'h0,        0, 0, 0, 0, 0, 0,  0,  0,  0,  0,  0,  0,  0,  2'b10, INST_MRET,  64'h8000_0200);

    rst_n = 0;
    rdata_in = 64'hcafe_f00d_1234_5678;
    zero_inputs();
    #2;
    chk("rst_busy", busy, 0);  chk("rst_ena", ena, 0);   chk("rst_ack", ack, 0);
    chk("rst_stall", stall, 0); chk("rst_addr", caddr, 0); chk("rst_wdata", cwd, 0);
    chk("rst_err", err, 0);    chk("rst_xop", xop, 0);   chk("rst_xpc", xpc, 0);
    @(negedge clk); rst_n = 1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      tv = vecs[i].tv; top = vecs[i].op; tpc = vecs[i].pc;
      lock = vecs[i].lock; iren = vecs[i].iren; iwen = vecs[i].iwen;
      ereq = vecs[i].ereq; eren = vecs[i].eren; ewen = vecs[i].ewen;
      iaddr = INS_ADDR; iwd = INS_WD; eaddr = EXC_ADDR; ewd = EXC_WD;
      #1;
      chk($sformatf("v%0d_busy", i),  busy,  vecs[i].busy);
      chk($sformatf("v%0d_ena", i),   ena,   vecs[i].ena);
      chk($sformatf("v%0d_ack", i),   ack,   vecs[i].ack);
      chk($sformatf("v%0d_stall", i), stall, vecs[i].stall);
      chk($sformatf("v%0d_addr", i),  caddr, vecs[i].sel_exc ? EXC_ADDR : INS_ADDR);
      chk($sformatf("v%0d_wdata", i), cwd,   vecs[i].sel_exc ? EXC_WD : INS_WD);
      chk($sformatf("v%0d_ren", i),   cren,  vecs[i].ren);
      chk($sformatf("v%0d_wen", i),   cwen,  vecs[i].wen);
      chk($sformatf("v%0d_err", i),   err,   vecs[i].err);
      chk($sformatf("v%0d_xop", i),   xop,   vecs[i].xop);
      chk($sformatf("v%0d_xpc", i),   xpc,   vecs[i].xpc);
    end
    chk("rdata_bcast", rdata_out, 64'hcafe_f00d_1234_5678);

    // exceptionU never answers: the port must be released after 64 S_EXC cycles.
    @(negedge clk);
    zero_inputs();
    tv = 1; top = INST_ECALL; tpc = 64'h8000_0300;
    @(negedge clk);
    tv = 0;
    found = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      if (ena) begin found = 1; break; end
    end
    chk("tmo_launch", found, 1);
    n = 0; ack_seen = 0;
    while (busy && n < 200) begin
      n++;
      if (ack) ack_seen = 1;
      @(negedge clk); #1;
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_no_ack", ack_seen, 0);
    chk("tmo_err", err, 2'b11);
    iwen = 1; iaddr = INS_ADDR; iwd = INS_WD;
    #1;
    chk("tmo_ins_stall", stall, 0);
    chk("tmo_ins_wen", cwen, 1);
    chk("tmo_ins_addr", caddr, INS_ADDR);

    // Asynchronous reset while exceptionU owns the port.
    @(negedge clk);
    zero_inputs();
    tv = 1; top = INST_MRET; tpc = 64'h1234;
    @(negedge clk);
    tv = 0;
    @(negedge clk); #1;
    chk("rmid_ena", ena, 1);
    eren = 1; ewen = 1; eaddr = EXC_ADDR; ewd = EXC_WD;
    #1;
    chk("rmid_exc_wen", cwen, 1);
    rst_n = 0; ereq = 1;
    #1;
    chk("rmid_busy", busy, 0);  chk("rmid_ena0", ena, 0);  chk("rmid_ack", ack, 0);
    chk("rmid_addr", caddr, 0); chk("rmid_ren", cren, 0);  chk("rmid_wen", cwen, 0);
    chk("rmid_err", err, 0);    chk("rmid_xop", xop, 0);   chk("rmid_xpc", xpc, 0);
    ereq = 0; eren = 0; ewen = 0;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    iren = 1; iaddr = INS_ADDR;
    #1;
    chk("post_busy", busy, 0);
    chk("post_stall", stall, 0);
    chk("post_ren", cren, 1);
    chk("post_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
